// File: rtl/icache_bus_pkg.sv
// icache_bus_pkg: shared word width, default line size and refill FSM states
package icache_bus_pkg;
  localparam int LINE_WORDS_DEF = 8;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, LATENCY, BURST} state_t;
endpackage

// File: rtl/refill_mem.sv
// refill_mem: single-clock simple dual-port RAM, read-first synchronous read
module refill_mem #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH),
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  // write and read share the edge; a colliding read returns the old word
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/icache_refill_responder.sv
// icache_refill_responder: streams one cache line per request from a backing word memory
module icache_refill_responder
  import icache_bus_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int MEM_WORDS = 1024,
  parameter int FIRST_BEAT_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [31:0]                  cmd_address,
  output logic                         rsp_valid,
  output logic [WORD_W-1:0]            rsp_data,
  output logic                         rsp_error,
  input  logic                         inject_wait,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
  input  logic [WORD_W-1:0]            mem_wdata
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = $clog2(LINE_WORDS);
  localparam int OW = BW + 2;
  localparam int LW = $clog2(FIRST_BEAT_LATENCY + 1);
  state_t r_state, w_state_nxt;
  logic [AW-BW-1:0] r_line, w_line_nxt;
  logic r_err, w_err_nxt;
  logic [BW-1:0] r_beat, w_beat_nxt;
  logic [LW-1:0] r_lat, w_lat_nxt;
  logic [AW-1:0] w_raddr;
  logic [WORD_W-1:0] w_rdata;
  logic w_unused;
  assign w_unused = ^cmd_address[OW-1:0];
  // next-state: accept in IDLE, count out the latency, step beats unless stalled
  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt = r_line;
    w_err_nxt = r_err;
    w_beat_nxt = r_beat;
    w_lat_nxt = r_lat;
    case (r_state)
      IDLE: if (cmd_valid) begin
        w_line_nxt = cmd_address[AW+1:OW];
        w_err_nxt = |cmd_address[31:AW+2];
        w_beat_nxt = '0;
        w_lat_nxt = '0;
        w_state_nxt = (FIRST_BEAT_LATENCY == 1) ? BURST : LATENCY;
      end
      LATENCY: begin
        w_lat_nxt = r_lat + 1'b1;
        if (r_lat == LW'(FIRST_BEAT_LATENCY - 2)) w_state_nxt = BURST;
      end
      BURST: if (!inject_wait) begin
        w_beat_nxt = r_beat + 1'b1;
        if (r_beat == BW'(LINE_WORDS - 1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // state registers; memory contents live in refill_mem and survive reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_line <= '0;
      r_err <= 1'b0;
      r_beat <= '0;
      r_lat <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_line <= w_line_nxt;
      r_err <= w_err_nxt;
      r_beat <= w_beat_nxt;
      r_lat <= w_lat_nxt;
    end
  end
  // the RAM fetches the word for next cycle's beat so it is ready when shown
  assign w_raddr = {w_line_nxt, w_beat_nxt};
  refill_mem #(.DEPTH(MEM_WORDS), .AW(AW), .DW(WORD_W)) u_mem (
    .clk(clk),
    .i_we(mem_we),
    .i_waddr(mem_waddr),
    .i_wdata(mem_wdata),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );
  assign cmd_ready = r_state == IDLE;
  assign rsp_valid = (r_state == BURST) && !inject_wait;
  assign rsp_error = rsp_valid && r_err;
  assign rsp_data = (rsp_valid && !r_err) ? w_rdata : '0;
endmodule

// File: doc/icache_refill_responder.md
ICACHE_REFILL_RESPONDER -- requirements
Module: icache_refill_responder

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, beats per cache line refill (power of two, 2..16).
REQ-002 SHALL have parameter MEM_WORDS, default 1024, depth of the backing word memory (power of two).
REQ-003 SHALL have parameter FIRST_BEAT_LATENCY, default 2, cycles from command acceptance to first response beat (>=1).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  line refill request valid.
REQ-007 SHALL have port cmd_ready  output  1  responder can accept a request.
REQ-008 SHALL have port cmd_address  input  32  byte address of requested line.
REQ-009 SHALL have port rsp_valid  output  1  response beat valid; no backpressure.
REQ-010 SHALL have port rsp_data  output  32  instruction word of current beat.
REQ-011 SHALL have port rsp_error  output  1  bus error flag for current beat.
REQ-012 SHALL have port inject_wait  input  1  test hook; suppresses a beat in the current cycle.
REQ-013 SHALL have ports mem_we input 1, mem_waddr input log2(MEM_WORDS), mem_wdata input 32: backing-memory preload/write port.

Function
REQ-014 SHALL implement states IDLE, LATENCY, BURST.
REQ-015 SHALL drive cmd_ready=1 only in IDLE; handshake = cmd_valid && cmd_ready on a rising edge.
REQ-016 SHALL, on handshake, latch line base = cmd_address with low log2(LINE_WORDS)+2 bits forced to zero, and enter LATENCY.
REQ-017 SHALL stay in LATENCY exactly FIRST_BEAT_LATENCY-1 cycles, so the first rsp_valid occurs FIRST_BEAT_LATENCY cycles after the handshake edge.
REQ-018 SHALL, in BURST, emit LINE_WORDS beats in ascending word order from line base (no critical-word-first wrap).
REQ-019 SHALL hold rsp_valid=0 and not advance the beat counter in any BURST cycle where inject_wait=1; LATENCY ignores inject_wait.
REQ-020 SHALL return to IDLE the cycle after the last beat; back-to-back: cmd_ready=1 in the cycle following the last beat.
REQ-021 SHALL flag a line as error when word index of line base >= MEM_WORDS (byte address >= 4*MEM_WORDS): every beat rsp_error=1, rsp_data=0.
REQ-022 SHALL drive rsp_error=0 and rsp_data=memory word for in-range beats; rsp_data/rsp_error are 0 whenever rsp_valid=0.
REQ-023 SHALL read memory synchronously; a mem_we to the word being read in the same cycle returns old data, later beats see new data.
REQ-024 SHALL accept mem_we in every state, independent of the refill FSM.
REQ-025 SHALL wrap the beat counter modulo LINE_WORDS with width log2(LINE_WORDS); no carry into line base.

Reset
REQ-026 SHALL, on reset assertion, immediately enter IDLE: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_error=0, beat counter=0.
REQ-027 SHALL abort any in-flight refill on reset mid-burst, emitting no further beats after deassertion.
REQ-028 SHALL NOT clear backing-memory contents on reset.

Structure
REQ-029 SHALL place LINE_WORDS default, word width 32, and the state enum in shared package icache_bus_pkg.
REQ-030 SHALL instantiate one sub-module refill_mem: single-clock simple dual-port RAM, one sync read port, one write port.

Verification
REQ-031 Preload words 0..7 = 0x1000+i; cmd at 0x00000004 -> handshake, rsp_valid 2 cycles later, 8 consecutive beats 0x1000..0x1007, rsp_error=0.
REQ-032 cmd at 0x00001000 with MEM_WORDS=1024 -> 8 beats rsp_error=1, rsp_data=0, then cmd_ready=1.
REQ-033 inject_wait=1 on 2nd and 3rd burst cycles -> rsp_valid gaps there, still exactly 8 beats in order, burst ends 2 cycles later.
REQ-034 cmd_valid held high continuously, two lines 0x00 and 0x20 -> second handshake the cycle after line-0 last beat; 16 beats total, correct order.
REQ-035 Assert reset after 3rd beat -> outputs 0 and cmd_ready=1 asynchronously; no beats after release; memory contents intact on next refill.
REQ-036 mem_we to word 5 with 0xDEAD in same cycle beat 5 is read -> beat 5 returns old value; next refill of same line returns 0xDEAD.
